clk_div_multi: RTL and testbench
================================

# clk_div_multi

Multi-channel programmable clock/tick generator; parametrised successor to the fixed single-output clock divider. Each channel divides the system clock by a runtime-writable divisor and produces a glitch-free, near-50% duty square wave plus a one-cycle period tick. Sits under the time-keeping logic and feeds display refresh, countdown timers and button scan from one instance.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- CNT_W, 27, counter/divisor width in bits
- DEFAULT_DIV, 100000, divisor loaded into every channel at reset (must be >= 2 and < 2^CNT_W)
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-low
- en  in  CHANNELS  per-channel run enable
- sync  in  1  phase-align strobe for all running channels
- div_wr  in  1  divisor write strobe, single cycle
- div_sel  in  max(1,$clog2(CHANNELS))  target channel of write
- div_val  in  CNT_W  new divisor value
- div_ack  out  1  one-cycle pulse: write accepted
- div_err  out  1  one-cycle pulse: write rejected
- clk_out  out  CHANNELS  divided square wave per channel
- tick  out  CHANNELS  one-cycle pulse at start of each channel period

## Operation
- Per channel: state IDLE/RUN, counter cnt, active divisor act, pending divisor pend with valid bit pv.
- IDLE: cnt=0, clk_out=0, tick=0. Edge with en=1 -> RUN with cnt=0.
- RUN: each edge cnt <= (cnt==act-1) ? 0 : cnt+1. Edge with en=0 -> IDLE (immediate stop, no period completion).
- clk_out=1 iff RUN and cnt < act-(act>>1) (high phase = ceil(act/2), low = floor(act/2)); tick=1 iff RUN and cnt==0.
- Writes: div_wr with div_sel<CHANNELS and div_val>=2 -> pend[sel]<=div_val, pv<=1, div_ack next cycle. Otherwise div_err next cycle, no state change. Second write before apply overwrites pend.
- Apply: at each wrap edge (cnt==act-1, RUN) or any edge while IDLE, if pv then act<=pend, pv<=0. A write accepted on the wrap edge itself is not used by that wrap; it applies at the following one.
- sync=1 at an edge: every RUN channel with en=1 loads cnt<=0 and applies pend if pv. IDLE channels ignore sync. en=0 overrides sync.
- Reset (rst=0 at edge): all channels IDLE, cnt=0, act=DEFAULT_DIV, pv=0; clk_out, tick, div_ack, div_err all 0. Reset mid-period discards pending writes.

## Timing
- All outputs registered; no combinational input-to-output paths. clk_out/tick values stated above are functions of the same cycle's registered cnt/state (compute from next-state).
- Enable latency: en high at edge k -> tick and clk_out high in cycle k+1.
- Disable latency: en low at edge k -> clk_out, tick low in cycle k+1.
- Write latency: div_wr at edge k -> div_ack/div_err in cycle k+1; back-to-back writes every cycle supported.
- Output period exactly act cycles; div=2 toggles every cycle; div=3 gives 2 high/1 low.
- Counter never exceeds act-1; act changes only at wrap, sync, or in IDLE, so clk_out never produces a runt pulse.

## Structure
- Package clk_div_pkg: channel state enum (IDLE, RUN), MIN_DIV=2 constant.
- Sub-module clk_div_channel: one channel (state, cnt, act, pend/pv, outputs); top instantiates CHANNELS copies and holds write decode/range check and ack/err registers.

## Test plan
- Reset then en[0]=1 with DEFAULT_DIV overridden to 4 -> clk_out[0] pattern 1,1,0,0 repeating; tick[0] every 4th cycle starting cycle after en.
- Write div_sel=1, div_val=3 while channel 1 runs at 4 -> div_ack next cycle; current period finishes at 4, following periods 2 high/1 low.
- Write div_val=1, then div_sel=CHANNELS (if CHANNELS<2^sel width) -> div_err each, act unchanged.
- Channels 0/1 at divisors 6/4 running out of phase, pulse sync -> both tick in next cycle, both clk_out high.
- en[2] dropped mid high phase -> clk_out[2] low next cycle; re-enable -> fresh period starting with tick.
- Assert rst low mid-period with a pending write -> all outputs 0 next cycle; after release and enable, period equals DEFAULT_DIV.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    // Smallest divisor that still yields a high and a low phase
    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: run state, period counter, active/pending divisor,
// registered square-wave and period-tick outputs.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W       = 27,
    parameter int unsigned DEFAULT_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    output logic             clk_out,
    output logic             tick
);

    ch_state_t        state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [CNT_W-1:0] act, nxt_act;
    logic [CNT_W-1:0] pend, nxt_pend;
    logic             pv, nxt_pv;
    logic             apply;
    logic             wrap;
    logic [CNT_W-1:0] nxt_high;
    logic             nxt_clk_out;
    logic             nxt_tick;

    // Next-state: counter advance/stop, divisor hand-over, and outputs
    // derived from the next state so they line up with the registered count.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_act   = act;
        nxt_pend  = pend;
        nxt_pv    = pv;
        apply     = 1'b0;
        wrap      = (cnt == act - CNT_W'(1));

        if (state == IDLE) begin
            apply   = 1'b1;
            nxt_cnt = '0;
            if (en) begin
                nxt_state = RUN;
            end
        end else if (!en) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
        end else if (sync || wrap) begin
            nxt_cnt = '0;
            apply   = 1'b1;
        end else begin
            nxt_cnt = cnt + CNT_W'(1);
        end

        // Apply uses the pending value from before this edge; a write on the
        // same edge becomes the new pending value for the next boundary.
        if (apply && pv) begin
            nxt_act = pend;
            nxt_pv  = 1'b0;
        end
        if (wr) begin
            nxt_pend = wr_val;
            nxt_pv   = 1'b1;
        end

        nxt_high    = nxt_act - (nxt_act >> 1);
        nxt_clk_out = (nxt_state == RUN) && (nxt_cnt < nxt_high);
        nxt_tick    = (nxt_state == RUN) && (nxt_cnt == '0);
    end

    // Channel state and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            act     <= CNT_W'(DEFAULT_DIV);
            pend    <= CNT_W'(DEFAULT_DIV);
            pv      <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            act     <= nxt_act;
            pend    <= nxt_pend;
            pv      <= nxt_pv;
            clk_out <= nxt_clk_out;
            tick    <= nxt_tick;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick generator: divisor write decode,
// range check, ack/err pulses, and CHANNELS divider instances.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 27,
    parameter int unsigned DEFAULT_DIV = 100000,
    localparam int unsigned SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                div_wr,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [CNT_W-1:0]    div_val,
    output logic                div_ack,
    output logic                div_err,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    logic sel_ok_c;
    logic val_ok_c;
    logic wr_ok_c;

    // Write qualification: channel index in range and divisor large enough.
    always_comb begin
        sel_ok_c = (32'(div_sel) < 32'(CHANNELS));
        val_ok_c = (div_val >= CNT_W'(MIN_DIV));
        wr_ok_c  = div_wr && sel_ok_c && val_ok_c;
    end

    // Registered one-cycle accept/reject pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_ack <= 1'b0;
            div_err <= 1'b0;
        end else begin
            div_ack <= wr_ok_c;
            div_err <= div_wr && !wr_ok_c;
        end
    end

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .sync    (sync),
            .wr      (wr_ok_c && (div_sel == SEL_W'(i))),
            .wr_val  (div_val),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: 3 channels, 8-bit counters,
// reset divisor 4. Expected outputs are queued as each vector is driven
// and compared one cycle later.
module tb_clk_div_multi;

    localparam int unsigned CH   = 3;
    localparam int unsigned CW   = 8;
    localparam int unsigned DDIV = 4;
    localparam int unsigned SW   = 2;

    typedef struct {
        string          name;
        logic           rst;
        logic [CH-1:0]  en;
        logic           sync;
        logic           wr;
        logic [SW-1:0]  sel;
        logic [CW-1:0]  val;
        logic [CH-1:0]  exp_clk;
        logic [CH-1:0]  exp_tick;
        logic           exp_ack;
        logic           exp_err;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [CH-1:0] en;
    logic          sync;
    logic          div_wr;
    logic [SW-1:0] div_sel;
    logic [CW-1:0] div_val;
    logic          div_ack;
    logic          div_err;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;

    int   n_vec;
    int   n_fail;
    vec_t exp_q[$];

    clk_div_multi #(
        .CHANNELS    (CH),
        .CNT_W       (CW),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .div_wr  (div_wr),
        .div_sel (div_sel),
        .div_val (div_val),
        .div_ack (div_ack),
        .div_err (div_err),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string nm, input logic r, input logic [CH-1:0] e,
                                input logic s, input logic w, input logic [SW-1:0] sl,
                                input logic [CW-1:0] v, input logic [CH-1:0] ec,
                                input logic [CH-1:0] et, input logic ea, input logic ee);
        vec_t t;
        t.name = nm; t.rst = r; t.en = e; t.sync = s; t.wr = w; t.sel = sl; t.val = v;
        t.exp_clk = ec; t.exp_tick = et; t.exp_ack = ea; t.exp_err = ee;
        return t;
    endfunction

    // Drive one vector for the next edge, queue its expectation, then
    // sample just after the edge and compare against the queue head.
    task automatic step(input vec_t v);
        vec_t e;
        rst     = v.rst;
        en      = v.en;
        sync    = v.sync;
        div_wr  = v.wr;
        div_sel = v.sel;
        div_val = v.val;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            e = exp_q.pop_front();
            if (clk_out !== e.exp_clk || tick !== e.exp_tick ||
                div_ack !== e.exp_ack || div_err !== e.exp_err) begin
                n_fail++;
                $display("FAIL %s: got clk_out=%b tick=%b ack=%b err=%b, want clk_out=%b tick=%b ack=%b err=%b",
                         e.name, clk_out, tick, div_ack, div_err,
                         e.exp_clk, e.exp_tick, e.exp_ack, e.exp_err);
            end
        end
    endtask

    task automatic run(input string nm, input logic r, input logic [CH-1:0] e,
                       input logic s, input logic w, input logic [SW-1:0] sl,
                       input logic [CW-1:0] v, input logic [CH-1:0] ec,
                       input logic [CH-1:0] et, input logic ea, input logic ee);
        step(mk(nm, r, e, s, w, sl, v, ec, et, ea, ee));
    endtask

    vec_t tbl[22];

    initial begin
        n_vec = 0; n_fail = 0;
        rst = 1'b0; en = '0; sync = 1'b0; div_wr = 1'b0; div_sel = '0; div_val = '0;

        // Reset, then ch0/ch1 at divisor 4; retune ch1 to 3; rejected writes
        tbl[0]  = mk("reset",       0, 3'b000, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0, 0);
        tbl[1]  = mk("en_c0",       1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b011, 3'b011, 0, 0);
        tbl[2]  = mk("d4_c1",       1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b011, 3'b000, 0, 0);
        tbl[3]  = mk("d4_c2",       1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0, 0);
        tbl[4]  = mk("d4_c3",       1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0, 0);
        tbl[5]  = mk("d4_wrap",     1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b011, 3'b011, 0, 0);
        tbl[6]  = mk("wr_c1_3",     1, 3'b011, 0, 1, 2'd1, 8'd3, 3'b011, 3'b000, 1, 0);
        tbl[7]  = mk("old_per_2",   1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0, 0);
        tbl[8]  = mk("old_per_3",   1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0, 0);
        tbl[9]  = mk("apply_wrap",  1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b011, 3'b011, 0, 0);
        tbl[10] = mk("d3_hi2",      1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b011, 3'b000, 0, 0);
        tbl[11] = mk("d3_lo",       1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0, 0);
        tbl[12] = mk("d3_wrap",     1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b010, 3'b010, 0, 0);
        tbl[13] = mk("mix_a",       1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b011, 3'b001, 0, 0);
        tbl[14] = mk("mix_b",       1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b001, 3'b000, 0, 0);
        tbl[15] = mk("mix_c",       1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b010, 3'b010, 0, 0);
        tbl[16] = mk("err_val1",    1, 3'b011, 0, 1, 2'd0, 8'd1, 3'b010, 3'b000, 0, 1);
        tbl[17] = mk("err_sel3",    1, 3'b011, 0, 1, 2'd3, 8'd5, 3'b001, 3'b001, 0, 1);
        tbl[18] = mk("keep_a",      1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b011, 3'b010, 0, 0);
        tbl[19] = mk("keep_b",      1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b010, 3'b000, 0, 0);
        tbl[20] = mk("keep_c",      1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0, 0);
        tbl[21] = mk("keep_wrap",   1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b011, 3'b011, 0, 0);

        for (int i = 0; i < 22; i++) begin
            step(tbl[i]);
        end

        // Sync: ch0 at 6 and ch1 at 4, out of phase, then aligned by sync
        run("rst_b",      0, 3'b000, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0, 0);
        run("wr_idle6",   1, 3'b000, 0, 1, 2'd0, 8'd6, 3'b000, 3'b000, 1, 0);
        run("en_c0_d6",   1, 3'b001, 0, 0, 2'd0, 8'd0, 3'b001, 3'b001, 0, 0);
        run("en_c1",      1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b011, 3'b010, 0, 0);
        run("phase_a",    1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b011, 3'b000, 0, 0);
        run("phase_b",    1, 3'b011, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0, 0);
        run("sync",       1, 3'b011, 1, 0, 2'd0, 8'd0, 3'b011, 3'b011, 0, 0);
        run("sync_en0",   1, 3'b001, 1, 0, 2'd0, 8'd0, 3'b001, 3'b001, 0, 0);

        // Back-to-back writes: second overwrites pending, applied at wrap
        run("wr_2",       1, 3'b001, 0, 1, 2'd0, 8'd2, 3'b001, 3'b000, 1, 0);
        run("wr_3",       1, 3'b001, 0, 1, 2'd0, 8'd3, 3'b001, 3'b000, 1, 0);
        run("d6_c3",      1, 3'b001, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0, 0);
        run("d6_c4",      1, 3'b001, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0, 0);
        run("d6_c5",      1, 3'b001, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0, 0);
        run("ovr_wrap",   1, 3'b001, 0, 0, 2'd0, 8'd0, 3'b001, 3'b001, 0, 0);
        run("ovr_hi",     1, 3'b001, 0, 0, 2'd0, 8'd0, 3'b001, 3'b000, 0, 0);
        run("ovr_lo",     1, 3'b001, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0, 0);
        run("ovr_wrap2",  1, 3'b001, 0, 0, 2'd0, 8'd0, 3'b001, 3'b001, 0, 0);

        // ch2 dropped mid high phase, then re-enabled for a fresh period
        run("en_c2",      1, 3'b101, 0, 0, 2'd0, 8'd0, 3'b101, 3'b100, 0, 0);
        run("c2_hi",      1, 3'b101, 0, 0, 2'd0, 8'd0, 3'b100, 3'b000, 0, 0);
        run("drop_c2",    1, 3'b001, 0, 0, 2'd0, 8'd0, 3'b001, 3'b001, 0, 0);
        run("reen_c2",    1, 3'b101, 0, 0, 2'd0, 8'd0, 3'b101, 3'b100, 0, 0);
        run("reen_hi",    1, 3'b101, 0, 0, 2'd0, 8'd0, 3'b100, 3'b000, 0, 0);

        // Reset mid-period with a pending write; afterwards default period
        run("pend_wr7",   1, 3'b101, 0, 1, 2'd2, 8'd7, 3'b001, 3'b001, 1, 0);
        run("rst_mid",    0, 3'b101, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0, 0);
        run("post_en",    1, 3'b100, 0, 0, 2'd0, 8'd0, 3'b100, 3'b100, 0, 0);
        run("post_c1",    1, 3'b100, 0, 0, 2'd0, 8'd0, 3'b100, 3'b000, 0, 0);
        run("post_c2",    1, 3'b100, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0, 0);
        run("post_c3",    1, 3'b100, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0, 0);
        run("post_wrap",  1, 3'b100, 0, 0, 2'd0, 8'd0, 3'b100, 3'b100, 0, 0);

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
